// File: rtl/rv_isa_pkg.sv
// RV32IM encoding constants shared by the instruction encoder and the core's decoder.
// Holds opcodes, op classes, control codes and the ctrl -> funct3/funct7 lookups.
package rv_isa_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_IALU   = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8,
    CLS_MUL    = 4'd9
  } op_class_e;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLTU = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;

  localparam logic [4:0] BR_BEQ  = 5'd0;
  localparam logic [4:0] BR_BNE  = 5'd1;
  localparam logic [4:0] BR_BLT  = 5'd2;
  localparam logic [4:0] BR_BGE  = 5'd3;
  localparam logic [4:0] BR_BLTU = 5'd4;
  localparam logic [4:0] BR_BGEU = 5'd5;

  localparam logic [4:0] MUL_FIRST = 5'h0A;
  localparam logic [4:0] MUL_LAST  = 5'h11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef struct packed {
    logic       valid;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } alu_code_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] funct3;
  } br_code_t;

  function automatic alu_code_t alu_decode(input logic [4:0] ctrl);
    alu_code_t r;
    r = '{valid: 1'b1, funct3: F3_ADD_SUB, funct7: F7_BASE};
    case (ctrl)
      ALU_ADD:  ;
      ALU_SUB:  r.funct7 = F7_ALT;
      ALU_AND:  r.funct3 = F3_AND;
      ALU_OR:   r.funct3 = F3_OR;
      ALU_XOR:  r.funct3 = F3_XOR;
      ALU_SLL:  r.funct3 = F3_SLL;
      ALU_SRL:  r.funct3 = F3_SRL_SRA;
      ALU_SRA:  begin
        r.funct3 = F3_SRL_SRA;
        r.funct7 = F7_ALT;
      end
      ALU_SLTU: r.funct3 = F3_SLTU;
      ALU_SLT:  r.funct3 = F3_SLT;
      default:  r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic br_code_t br_decode(input logic [4:0] ctrl);
    br_code_t r;
    r = '{valid: 1'b1, funct3: F3_BEQ};
    case (ctrl)
      BR_BEQ:  ;
      BR_BNE:  r.funct3 = F3_BNE;
      BR_BLT:  r.funct3 = F3_BLT;
      BR_BGE:  r.funct3 = F3_BGE;
      BR_BLTU: r.funct3 = F3_BLTU;
      BR_BGEU: r.funct3 = F3_BGEU;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor handshake and imem write port of the instruction encoder.
// The master side produces descriptors and observes writes; the encoder is the slave.
interface instr_encoder_if #(parameter int AW = 32);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op_class;
  logic [4:0]    ctrl;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [31:0]   imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output in_valid, op_class, ctrl, rd, rs1, rs2, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, op_class, ctrl, rd, rs1, rs2, imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational descriptor packer: builds the RV32IM word and flags descriptors
// whose control code or immediate cannot be encoded.
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [3:0]  op_class,
  input  logic [4:0]  ctrl,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic      imm_i_ok;
  logic      imm_b_ok;
  logic      imm_j_ok;
  logic      imm_u_ok;
  logic      shamt_ok;
  logic [2:0] mul_f3;
  alu_code_t alu;
  br_code_t  br;

  // Signed range checks: every bit above the field's sign bit must match it.
  assign imm_i_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign imm_b_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
  assign imm_j_ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
  assign imm_u_ok = (imm[11:0] == '0);
  assign shamt_ok = (imm[31:5] == '0);

  assign alu = alu_decode(ctrl);
  assign br  = br_decode(ctrl);

  // 0x0A..0x11 carry low bits 2..7,0,1, so subtracting 2 modulo 8 yields funct3 0..7.
  assign mul_f3 = ctrl[2:0] - 3'd2;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op_class_e'(op_class))
      CLS_R: begin
        illegal = !alu.valid;
        word    = {alu.funct7, rs2, rs1, alu.funct3, rd, OPC_OP};
      end
      CLS_IALU: begin
        if (!alu.valid || ctrl == ALU_SUB) begin
          illegal = 1'b1;
        end else if (alu.funct3 == F3_SLL || alu.funct3 == F3_SRL_SRA) begin
          illegal = !shamt_ok;
          word    = {alu.funct7, imm[4:0], rs1, alu.funct3, rd, OPC_OP_IMM};
        end else begin
          illegal = !imm_i_ok;
          word    = {imm[11:0], rs1, alu.funct3, rd, OPC_OP_IMM};
        end
      end
      CLS_LOAD: begin
        illegal = !(ctrl[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || !imm_i_ok;
        word    = {imm[11:0], rs1, ctrl[2:0], rd, OPC_LOAD};
      end
      CLS_STORE: begin
        illegal = (ctrl[2:0] > 3'd2) || !imm_i_ok;
        word    = {imm[11:5], rs2, rs1, ctrl[2:0], imm[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        illegal = !br.valid || !imm_b_ok;
        word    = {imm[12], imm[10:5], rs2, rs1, br.funct3, imm[4:1], imm[11], OPC_BRANCH};
      end
      CLS_JAL: begin
        illegal = !imm_j_ok;
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      CLS_JALR: begin
        illegal = !imm_i_ok;
        word    = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      end
      CLS_LUI: begin
        illegal = !imm_u_ok;
        word    = {imm[31:12], rd, OPC_LUI};
      end
      CLS_AUIPC: begin
        illegal = !imm_u_ok;
        word    = {imm[31:12], rd, OPC_AUIPC};
      end
      CLS_MUL: begin
        illegal = (ctrl < MUL_FIRST) || (ctrl > MUL_LAST);
        word    = {F7_MULDIV, rs2, rs1, mul_f3, rd, OPC_OP};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts descriptors, packs them and writes legal words into imem
// at base + 4k, dropping illegal ones with an err pulse.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [AW-1:0]                base_addr,
  instr_encoder_if.slave               bus,
  output logic                         err,
  output logic [7:0]                   err_count,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   words
);

  localparam int WW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_e;

  state_e        state;
  logic [AW-1:0] next_addr;
  logic [31:0]   word;
  logic          illegal;
  logic          accept;

  instr_pack u_pack (
    .op_class (bus.op_class),
    .ctrl     (bus.ctrl),
    .rd       (bus.rd),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .imm      (bus.imm),
    .word     (word),
    .illegal  (illegal)
  );

  // start wins over a coincident descriptor, so ready is masked by it.
  assign bus.in_ready = (state == S_LOAD) && !start;
  assign accept       = bus.in_valid && bus.in_ready;
  assign full         = (state == S_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      next_addr      <= '0;
      words          <= '0;
      err_count      <= '0;
      err            <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      err         <= 1'b0;
      if (start) begin
        state     <= S_LOAD;
        next_addr <= base_addr;
        words     <= '0;
        err_count <= '0;
      end else if (accept) begin
        if (illegal) begin
          err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          bus.imem_we    <= 1'b1;
          bus.imem_addr  <= next_addr;
          bus.imem_wdata <= word;
          next_addr      <= next_addr + AW'(4);
          words          <= words + WW'(1);
          if (words == WW'(DEPTH - 1)) state <= S_FULL;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder with an encoding model built
// from the RV32IM field layouts and a session-level view of the loader.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int WW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          err;
  logic [7:0]    err_count;
  logic          full;
  logic [WW-1:0] words;

  instr_encoder_if #(.AW(AW)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .err       (err),
    .err_count (err_count),
    .full      (full),
    .words     (words)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int alu_f3 [10] = '{0, 0, 7, 6, 4, 1, 5, 5, 3, 2};
  int alu_f7 [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
  int br_f3  [6]  = '{0, 1, 4, 5, 6, 7};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference encoder: legality from integer ranges, word assembled field by field.
  function automatic void model_encode(input int cls, input int c, input int rd, input int rs1,
                                       input int rs2, input logic [31:0] imm,
                                       output logic [31:0] w, output logic bad);
    int s;
    int f3;
    s   = $signed(imm);
    w   = '0;
    bad = 1'b0;
    case (cls)
      0: if (c > 9) bad = 1'b1;
         else w = 32'h33 | rd << 7 | alu_f3[c] << 12 | rs1 << 15 | rs2 << 20 | alu_f7[c] << 25;
      1: if (c > 9 || c == 1) bad = 1'b1;
         else if (c >= 5 && c <= 7) begin
           if (s < 0 || s > 31) bad = 1'b1;
           else w = 32'h13 | rd << 7 | alu_f3[c] << 12 | rs1 << 15 | (alu_f7[c] * 32 + s) << 20;
         end else begin
           if (s < -2048 || s > 2047) bad = 1'b1;
           else w = 32'h13 | rd << 7 | alu_f3[c] << 12 | rs1 << 15 | (imm & 32'hFFF) << 20;
         end
      2: begin
        f3 = c % 8;
        if (!(f3 inside {0, 1, 2, 4, 5}) || s < -2048 || s > 2047) bad = 1'b1;
        else w = 32'h03 | rd << 7 | f3 << 12 | rs1 << 15 | (imm & 32'hFFF) << 20;
      end
      3: begin
        f3 = c % 8;
        if (f3 > 2 || s < -2048 || s > 2047) bad = 1'b1;
        else w = 32'h23 | (imm & 31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((imm >> 5) & 127) << 25;
      end
      4: if (c > 5 || s < -4096 || s > 4094 || s % 2 != 0) bad = 1'b1;
         else w = 32'h63 | ((imm >> 11) & 1) << 7 | ((imm >> 1) & 15) << 8 | br_f3[c] << 12 |
                  rs1 << 15 | rs2 << 20 | ((imm >> 5) & 63) << 25 | ((imm >> 12) & 1) << 31;
      5: if (s < -1048576 || s > 1048574 || s % 2 != 0) bad = 1'b1;
         else w = 32'h6F | rd << 7 | ((imm >> 12) & 255) << 12 | ((imm >> 11) & 1) << 20 |
                  ((imm >> 1) & 1023) << 21 | ((imm >> 20) & 1) << 31;
      6: if (s < -2048 || s > 2047) bad = 1'b1;
         else w = 32'h67 | rd << 7 | rs1 << 15 | (imm & 32'hFFF) << 20;
      7: if ((imm & 32'hFFF) != 0) bad = 1'b1;
         else w = (imm & 32'hFFFFF000) | rd << 7 | 32'h37;
      8: if ((imm & 32'hFFF) != 0) bad = 1'b1;
         else w = (imm & 32'hFFFFF000) | rd << 7 | 32'h17;
      9: if (c < 10 || c > 17) bad = 1'b1;
         else w = 32'h33 | rd << 7 | (c - 10) << 12 | rs1 << 15 | rs2 << 20 | 1 << 25;
      default: bad = 1'b1;
    endcase
  endfunction

  // Session-level model: a session holds a word count, next address and error count.
  logic          m_active = 1'b0;
  int            m_words = 0;
  int            m_errc = 0;
  logic [AW-1:0] m_addr = '0;
  logic          e_we = 1'b0;
  logic          e_err = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [31:0]   e_wdata = '0;

  always @(negedge clk) begin : compare
    logic [31:0] w;
    logic        bad;
    logic        rdy;
    if (!rst_n) begin
      m_active = 1'b0; m_words = 0; m_errc = 0; m_addr = '0;
      e_we = 1'b0; e_err = 1'b0; e_addr = '0; e_wdata = '0;
    end
    rdy = m_active && (m_words < DEPTH) && !start;
    checkOutput("imem_we", 32'(bus.imem_we), 32'(e_we));
    if (e_we || !rst_n) begin
      checkOutput("imem_addr", bus.imem_addr, e_addr);
      checkOutput("imem_wdata", bus.imem_wdata, e_wdata);
    end
    checkOutput("err", 32'(err), 32'(e_err));
    checkOutput("err_count", 32'(err_count), m_errc);
    checkOutput("words", 32'(words), m_words);
    checkOutput("full", 32'(full), 32'(m_active && m_words == DEPTH));
    checkOutput("in_ready", 32'(bus.in_ready), 32'(rdy));
    if (rst_n) begin
      e_we  = 1'b0;
      e_err = 1'b0;
      if (start) begin
        m_active = 1'b1; m_addr = base_addr; m_words = 0; m_errc = 0;
      end else if (bus.in_valid && rdy) begin
        model_encode(int'(bus.op_class), int'(bus.ctrl), int'(bus.rd), int'(bus.rs1),
                     int'(bus.rs2), bus.imm, w, bad);
        if (bad) begin
          e_err = 1'b1;
          if (m_errc < 255) m_errc++;
        end else begin
          e_we = 1'b1; e_addr = m_addr; e_wdata = w;
          m_addr = m_addr + 4;
          m_words++;
        end
      end
    end
  end

  // Holds one set of inputs across one rising edge; returns 1 time unit after it.
  task automatic applyStimulus(input logic s, input logic [31:0] base, input logic v, input int cls,
                               input int c, input int r_d, input int r_s1, input int r_s2,
                               input logic [31:0] im);
    start        = s;
    base_addr    = base;
    bus.in_valid = v;
    bus.op_class = 4'(cls);
    bus.ctrl     = 5'(c);
    bus.rd       = 5'(r_d);
    bus.rs1      = 5'(r_s1);
    bus.rs2      = 5'(r_s2);
    bus.imm      = im;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  logic [31:0] pin_w;
  logic        pin_bad;
  int          n_wr;
  int          cls_r;
  int          ctl_r;
  int          mode;
  logic [31:0] imm_r;

  initial begin
    bus.in_valid = 1'b0; bus.op_class = '0; bus.ctrl = '0;
    bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("rst_imem_we", 32'(bus.imem_we), 32'h0);
    checkOutput("rst_imem_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_imem_wdata", bus.imem_wdata, 32'h0);
    checkOutput("rst_err_count", 32'(err_count), 32'h0);
    checkOutput("rst_words", 32'(words), 32'h0);
    checkOutput("rst_full", 32'(full), 32'h0);
    rst_n = 1'b1;

    model_encode(0, 1, 3, 1, 2, 32'h0, pin_w, pin_bad);
    checkOutput("model_r_sub", pin_w, 32'h402081B3);
    model_encode(1, 7, 5, 5, 0, 32'h3, pin_w, pin_bad);
    checkOutput("model_srai", pin_w, 32'h4032D293);
    model_encode(4, 0, 0, 1, 2, -32'sd8, pin_w, pin_bad);
    checkOutput("model_beq", pin_w, 32'hFE208CE3);
    model_encode(7, 0, 1, 0, 0, 32'h12345000, pin_w, pin_bad);
    checkOutput("model_lui", pin_w, 32'h123450B7);
    model_encode(1, 0, 1, 0, 0, 32'd2048, pin_w, pin_bad);
    checkOutput("model_imm_bad", 32'(pin_bad), 32'h1);

    applyStimulus(1'b1, 32'h100, 1'b0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 0, 1, 3, 1, 2, 32'h0);
    checkOutput("tp_r_we", 32'(bus.imem_we), 32'h1);
    checkOutput("tp_r_addr", bus.imem_addr, 32'h100);
    checkOutput("tp_r_wdata", bus.imem_wdata, 32'h402081B3);

    applyStimulus(1'b1, 32'h100, 1'b0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1, 7, 5, 5, 0, 32'h3);
    checkOutput("tp_srai_addr", bus.imem_addr, 32'h100);
    checkOutput("tp_srai_wdata", bus.imem_wdata, 32'h4032D293);
    applyStimulus(1'b0, 32'h0, 1'b1, 4, 0, 0, 1, 2, -32'sd8);
    checkOutput("tp_beq_addr", bus.imem_addr, 32'h104);
    checkOutput("tp_beq_wdata", bus.imem_wdata, 32'hFE208CE3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1, 0, 1, 1, 0, 32'd2048);
    checkOutput("tp_bad_err", 32'(err), 32'h1);
    checkOutput("tp_bad_we", 32'(bus.imem_we), 32'h0);
    checkOutput("tp_bad_errcnt", 32'(err_count), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b1, 7, 0, 1, 0, 0, 32'h12345000);
    checkOutput("tp_lui_addr", bus.imem_addr, 32'h108);
    checkOutput("tp_lui_wdata", bus.imem_wdata, 32'h123450B7);
    applyStimulus(1'b0, 32'h0, 1'b1, 7, 0, 1, 0, 0, 32'h12345001);
    checkOutput("tp_lui_bad_err", 32'(err), 32'h1);
    checkOutput("tp_lui_bad_cnt", 32'(err_count), 32'h2);

    applyStimulus(1'b1, 32'h200, 1'b0, 0, 0, 0, 0, 0, 32'h0);
    n_wr = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1, 0, i + 1, 2, 0, 32'(i));
      if (bus.imem_we) n_wr++;
    end
    checkOutput("burst_writes", n_wr, 32'd4);
    checkOutput("burst_full", 32'(full), 32'h1);
    checkOutput("burst_in_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("burst_words", 32'(words), 32'd4);
    applyStimulus(1'b1, 32'h300, 1'b0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("restart_full", 32'(full), 32'h0);
    checkOutput("restart_words", 32'(words), 32'h0);

    for (int i = 0; i < 260; i++) applyStimulus(1'b0, 32'h0, 1'b1, 10, 0, 0, 0, 0, 32'h0);
    idle();
    checkOutput("sat_err_count", 32'(err_count), 32'd255);
    checkOutput("sat_words", 32'(words), 32'h0);

    applyStimulus(1'b1, 32'hFFFFFFF8, 1'b0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 5, 0, 1, 0, 0, 32'h800);
    checkOutput("wrap_addr", bus.imem_addr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 9, 12, 4, 5, 6, 32'h0);
    checkOutput("wrap_addr2", bus.imem_addr, 32'h4);

    for (int i = 0; i < 3000; i++) begin
      cls_r = $urandom_range(0, 11);
      ctl_r = (cls_r == 2 || cls_r == 3) ? $urandom_range(0, 7) : $urandom_range(0, 19);
      mode  = $urandom_range(0, 4);
      case (mode)
        0: imm_r = $urandom();
        1: imm_r = 32'($urandom_range(0, 8400)) - 32'd4200;
        2: imm_r = $urandom() & 32'hFFFFF000;
        3: imm_r = 32'($urandom_range(0, 40));
        default: imm_r = 32'($urandom_range(0, 2200000)) - 32'd1100000;
      endcase
      applyStimulus($urandom_range(0, 99) < 10, $urandom() & 32'hFFFFFFFC, $urandom_range(0, 3) != 0,
                    cls_r, ctl_r, $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), imm_r);
    end

    applyStimulus(1'b1, 32'h300, 1'b0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 0, 2, 7, 8, 9, 32'h0);
    checkOutput("arst_pre_we", 32'(bus.imem_we), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_we", 32'(bus.imem_we), 32'h0);
    checkOutput("arst_addr", bus.imem_addr, 32'h0);
    checkOutput("arst_wdata", bus.imem_wdata, 32'h0);
    checkOutput("arst_words", 32'(words), 32'h0);
    checkOutput("arst_in_ready", 32'(bus.in_ready), 32'h0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    applyStimulus(1'b0, 32'h0, 1'b1, 0, 0, 1, 1, 1, 32'h0);
    checkOutput("post_rst_idle_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("post_rst_idle_we", 32'(bus.imem_we), 32'h0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
